// File: rtl/channel_burst_injector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_chan_pkg
// Description : Shared types and constants for the coded-symbol channel model
//               sitting between the convolutional encoder and the Viterbi
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_chan_pkg;

  localparam int          SYM_W     = 2;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } chan_state_t;

  // Number of set bits in a symbol-wide mask.
  function automatic logic [1:0] sym_popcount(input sym_t m);
    return {1'b0, m[1]} + {1'b0, m[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/channel_burst_injector_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : lfsr32
// Description : 32-bit right-shifting Galois LFSR that steps only when adv is
//               high. An all-zero seed would lock up, so it is replaced by 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr32
  import viterbi_chan_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] state
);

  localparam logic [31:0] c_seed = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] r_state;
  logic [31:0] w_next;

  // Galois step: shift right, fold the polynomial in when a one drops out.
  always_comb begin
    w_next = {1'b0, r_state[31:1]};
    if (r_state[0]) begin
      w_next = w_next ^ LFSR_POLY;
    end
  end

  // State register, advanced once per accepted symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_seed;
    end else if (adv) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/channel_burst_injector.sv
`default_nettype none
// ============================================================================
// Module      : channel_burst_injector
// Description : One-stage channel model that forwards 2-bit coded symbols and
//               overlays burst errors triggered by an LFSR or a force pulse.
//               Also accumulates windowed symbol / flipped-bit statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_burst_injector
  import viterbi_chan_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned BURST_MAX = 4,
  parameter logic [31:0] SEED      = 32'h1,
  parameter int unsigned WINDOW    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [1:0]  sym_i,
  input  logic        inject_en_i,
  input  logic        force_i,
  input  logic [3:0]  burst_len_i,
  input  logic [1:0]  err_mask_i,
  output logic        valid_o,
  output logic [1:0]  sym_o,
  output logic [1:0]  err_o,
  output logic [15:0] word_ct_o,
  output logic [15:0] bad_bit_ct_o,
  output logic        window_done_o
);

  // Low N bits of the LFSR must all be ones to fire a random burst.
  localparam logic [31:0] c_trig_mask = (32'h1 << N) - 32'h1;
  localparam logic [3:0]  c_len_max   = 4'(BURST_MAX);
  localparam logic [15:0] c_window    = 16'(WINDOW);

  chan_state_t r_state;
  logic [3:0]  r_rem;
  logic        r_valid;
  sym_t        r_sym;
  sym_t        r_err;
  logic [15:0] r_word_ct;
  logic [15:0] r_bad_ct;

  logic [31:0] w_lfsr;
  logic [3:0]  w_len;
  logic        w_lfsr_hit;
  logic        w_trigger;
  logic        w_corrupt;
  sym_t        w_mask;

  lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (valid_i),
    .state (w_lfsr)
  );

  // Trigger decode and the mask applied to the current symbol.
  always_comb begin
    w_len      = (burst_len_i > c_len_max) ? c_len_max : burst_len_i;
    // Bits outside the trigger field are forced to one so only the field matters.
    w_lfsr_hit = &(w_lfsr | ~c_trig_mask);
    w_trigger  = valid_i && (r_state == IDLE) && (w_len != 4'd0) &&
                 (force_i || (inject_en_i && w_lfsr_hit));
    w_corrupt  = valid_i && ((r_state == BURST) || w_trigger);
    w_mask     = w_corrupt ? err_mask_i : 2'b00;
  end

  // Burst FSM; length is captured only at trigger time, so a burst never extends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rem   <= 4'd0;
    end else if (valid_i) begin
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_rem   <= w_len - 4'd1;
            r_state <= (w_len > 4'd1) ? BURST : IDLE;
          end
        end
        BURST: begin
          r_rem <= r_rem - 4'd1;
          if (r_rem == 4'd1) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rem   <= 4'd0;
        end
      endcase
    end
  end

  // Output stage: idle cycles present an all-zero symbol and mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_sym   <= 2'b00;
      r_err   <= 2'b00;
    end else begin
      r_valid <= valid_i;
      r_sym   <= valid_i ? (sym_i ^ w_mask) : 2'b00;
      r_err   <= w_mask;
    end
  end

  // Windowed statistics, frozen once the window is full until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_ct <= 16'd0;
      r_bad_ct  <= 16'd0;
    end else if (valid_i && (r_word_ct < c_window)) begin
      r_word_ct <= r_word_ct + 16'd1;
      r_bad_ct  <= r_bad_ct + {14'd0, sym_popcount(w_mask)};
    end
  end

  assign valid_o       = r_valid;
  assign sym_o         = r_sym;
  assign err_o         = r_err;
  assign word_ct_o     = r_word_ct;
  assign bad_bit_ct_o  = r_bad_ct;
  assign window_done_o = (r_word_ct == c_window);

endmodule
`default_nettype wire

// File: tb/tb_channel_burst_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_burst_injector
// Description : Scoreboard bench for the burst-error channel model. The
//               driver queues the expected {sym_o, err_o} per valid symbol;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_burst_injector;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [1:0]  sym_i;
  logic        inject_en_i;
  logic        force_i;
  logic [3:0]  burst_len_i;
  logic [1:0]  err_mask_i;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic [1:0]  err_o;
  logic [15:0] word_ct_o;
  logic [15:0] bad_bit_ct_o;
  logic        window_done_o;

  int          n_vec;
  int          n_err;
  logic [3:0]  exp_q[$];

  channel_burst_injector #(
    .N         (4),
    .BURST_MAX (4),
    .SEED      (32'h1),
    .WINDOW    (256)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .sym_i         (sym_i),
    .inject_en_i   (inject_en_i),
    .force_i       (force_i),
    .burst_len_i   (burst_len_i),
    .err_mask_i    (err_mask_i),
    .valid_o       (valid_o),
    .sym_o         (sym_o),
    .err_o         (err_o),
    .word_ct_o     (word_ct_o),
    .bad_bit_ct_o  (bad_bit_ct_o),
    .window_done_o (window_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Galois LFSR step for the random-rate expectations.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: valid outputs are matched against the queue, idle outputs must be zero.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got sym=%b err=%b with empty queue", sym_o, err_o);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("sym_err", {28'd0, sym_o, err_o}, {28'd0, e});
        end
      end else begin
        check("idle_zero", {30'd0, sym_o | err_o}, 32'd0);
      end
    end
  end

  // Present one cycle of input; corrupt selects the expected mask application.
  task automatic send(input logic v, input logic [1:0] s, input logic f, input logic corrupt);
    valid_i = v;
    sym_i   = s;
    force_i = f;
    if (v) begin
      if (corrupt) exp_q.push_back({s ^ err_mask_i, err_mask_i});
      else         exp_q.push_back({s, 2'b00});
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    force_i = 1'b0;
    sym_i   = 2'b00;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    force_i = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_outputs", {28'd0, valid_o, window_done_o, sym_o | err_o},  32'd0);
    check("rst_counters", {word_ct_o, bad_bit_ct_o}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    #1;
    rst = 1'b1;
  endtask

  task automatic drain_check(input string name);
    @(negedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] lf;
    int          hits;
    logic        hit;
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b0;
    valid_i     = 1'b0;
    sym_i       = 2'b00;
    inject_en_i = 1'b0;
    force_i     = 1'b0;
    burst_len_i = 4'd0;
    err_mask_i  = 2'b00;
    #23;
    rst = 1'b1;

    // Clean channel with window saturation.
    do_reset();
    burst_len_i = 4'd3;
    err_mask_i  = 2'b11;
    for (int i = 0; i < 300; i++) begin
      send(1'b1, 2'(i), 1'b0, 1'b0);
      check("window_done", {31'd0, window_done_o}, (i >= 255) ? 32'd1 : 32'd0);
    end
    check("clean_word_ct", {16'd0, word_ct_o}, 32'd256);
    check("clean_bad_ct", {16'd0, bad_bit_ct_o}, 32'd0);
    drain_check("clean_drain");

    // Forced double burst on symbol 5.
    do_reset();
    burst_len_i = 4'd2;
    err_mask_i  = 2'b10;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 2'((i * 3) + 1), (i == 5), (i == 5) || (i == 6));
    end
    check("double_bad_ct", {16'd0, bad_bit_ct_o}, 32'd2);
    check("double_word_ct", {16'd0, word_ct_o}, 32'd8);
    drain_check("double_drain");

    // Length clamps to 4; a second force inside the burst does not extend it.
    do_reset();
    burst_len_i = 4'd9;
    err_mask_i  = 2'b11;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 2'(i + 2), (i == 0) || (i == 2), (i < 4));
    end
    check("clamp_bad_ct", {16'd0, bad_bit_ct_o}, 32'd8);
    drain_check("clamp_drain");

    // Gapped valid: idle cycles consume nothing from the burst.
    do_reset();
    burst_len_i = 4'd3;
    err_mask_i  = 2'b01;
    send(1'b1, 2'b10, 1'b1, 1'b1);
    send(1'b0, 2'b11, 1'b0, 1'b0);
    send(1'b1, 2'b00, 1'b0, 1'b1);
    send(1'b0, 2'b01, 1'b1, 1'b0);
    send(1'b1, 2'b11, 1'b0, 1'b1);
    send(1'b1, 2'b01, 1'b0, 1'b0);
    send(1'b1, 2'b10, 1'b0, 1'b0);
    check("gap_bad_ct", {16'd0, bad_bit_ct_o}, 32'd3);
    check("gap_word_ct", {16'd0, word_ct_o}, 32'd5);
    drain_check("gap_drain");

    // Random rate: single-symbol bursts predicted by a reference LFSR.
    do_reset();
    inject_en_i = 1'b1;
    burst_len_i = 4'd1;
    err_mask_i  = 2'b01;
    lf   = 32'h1;
    hits = 0;
    for (int i = 0; i < 4096; i++) begin
      hit = (lf[3:0] == 4'hF);
      if (hit && (i < 256)) hits++;
      send(1'b1, 2'(i >> 1), 1'b0, hit);
      lf = ref_step(lf);
    end
    check("rand_bad_ct", {16'd0, bad_bit_ct_o}, hits);
    check("rand_word_ct", {16'd0, word_ct_o}, 32'd256);
    drain_check("rand_drain");

    // Reset mid-burst, then the LFSR must replay from SEED.
    do_reset();
    inject_en_i = 1'b0;
    burst_len_i = 4'd8;
    err_mask_i  = 2'b11;
    send(1'b1, 2'b00, 1'b1, 1'b1);
    send(1'b1, 2'b01, 1'b0, 1'b1);
    send(1'b1, 2'b10, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_outputs", {28'd0, valid_o, window_done_o, sym_o | err_o}, 32'd0);
    check("midrst_counters", {word_ct_o, bad_bit_ct_o}, 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_queue", exp_q.size(), 0);
    exp_q.delete();
    #1;
    rst = 1'b1;
    inject_en_i = 1'b1;
    burst_len_i = 4'd1;
    err_mask_i  = 2'b10;
    lf   = 32'h1;
    hits = 0;
    for (int i = 0; i < 64; i++) begin
      hit = (lf[3:0] == 4'hF);
      if (hit) hits++;
      send(1'b1, 2'(i), 1'b0, hit);
      lf = ref_step(lf);
    end
    check("replay_bad_ct", {16'd0, bad_bit_ct_o}, hits);
    drain_check("replay_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
